// File: rtl/fetch_sequencer.sv
// Fetch/decode control for the PC, AR and IR registers: drives their strobes through
// fetch -> decode -> optional indirect -> execute handoff, with a memory-ack timeout.
//
// state | meaning
// IDLE  | stopped, waiting for start
// BOOT  | clear PC after reset or error
// T0    | AR <= PC
// T1    | read instruction; IR <= mem, PC++ on ack
// T2    | AR <= address field of IR
// T3    | indirect read; AR <= mem on ack
// EX    | instruction handed to execute stage
// ERR   | memory ack timeout, waiting for start
module fetch_sequencer #(
  parameter int DW      = 16,
  parameter int AW      = 12,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          asyncclear_n,
  input  logic          start,
  input  logic          halt,
  input  logic          mem_ack,
  input  logic [DW-1:0] ir_q,
  input  logic          exec_done,
  output logic          mem_rd,
  output logic          ar_load,
  output logic [1:0]    ar_src,
  output logic          pc_inc,
  output logic          pc_clear,
  output logic          ir_load,
  output logic          instr_valid,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [2:0] {IDLE, BOOT, T0, T1, T2, T3, EX, ERR} state_t;

  localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       booted, halt_pend;
  logic [7:0] tcnt;
  logic       mem_rd_q, ar_load_q, pc_clear_q, instr_valid_q, busy_q, timeout_err_q;
  logic [1:0] ar_src_q;
  logic       in_read, ack_t1, ack_t3;

  // Only the indirect bit is decoded here; the address field goes straight to the AR mux.
  logic unused_ir;
  assign unused_ir = ^ir_q[DW-2:0];

  assign in_read = (state == T1) || (state == T3);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = booted ? T0 : BOOT;
      BOOT: state_nxt = T0;
      T0:   state_nxt = T1;
      T1: begin
        if (mem_ack)              state_nxt = T2;
        else if (tcnt == TC_LAST) state_nxt = ERR;
      end
      T2:   state_nxt = ir_q[DW-1] ? T3 : EX;
      T3: begin
        if (mem_ack)              state_nxt = EX;
        else if (tcnt == TC_LAST) state_nxt = ERR;
      end
      EX:   if (exec_done) state_nxt = (halt_pend || halt) ? IDLE : T0;
      ERR:  if (start) state_nxt = BOOT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyncclear_n) begin
    if (!asyncclear_n) begin
      state         <= IDLE;
      booted        <= 1'b0;
      halt_pend     <= 1'b0;
      tcnt          <= '0;
      mem_rd_q      <= 1'b0;
      ar_load_q     <= 1'b0;
      ar_src_q      <= 2'd0;
      pc_clear_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == BOOT) booted <= 1'b1;

      if (state == EX && exec_done)            halt_pend <= 1'b0;
      else if (state != IDLE && state != ERR)  halt_pend <= halt_pend | halt;

      // Wait counter restarts on every entry into a read state.
      if ((state_nxt == T1 || state_nxt == T3) && state_nxt != state) tcnt <= '0;
      else if (in_read && !mem_ack)                                   tcnt <= tcnt + 8'd1;

      // Moore outputs are registered from the next state.
      mem_rd_q      <= (state_nxt == T1) || (state_nxt == T3);
      ar_load_q     <= (state_nxt == T0) || (state_nxt == T2);
      ar_src_q      <= (state_nxt == T2) ? 2'd1 : 2'd0;
      pc_clear_q    <= (state_nxt == BOOT);
      instr_valid_q <= (state_nxt == EX);
      busy_q        <= (state_nxt != IDLE) && (state_nxt != ERR);
      timeout_err_q <= (state_nxt == ERR);
    end
  end

  // Read-completion strobes must act on the ack cycle itself, so they bypass the registers.
  assign ack_t1 = (state == T1) && mem_ack;
  assign ack_t3 = (state == T3) && mem_ack;

  assign mem_rd      = mem_rd_q;
  assign ar_load     = ar_load_q | ack_t3;
  assign ar_src      = ar_src_q | (ack_t3 ? 2'd2 : 2'd0);
  assign pc_inc      = ack_t1;
  assign ir_load     = ack_t1;
  assign pc_clear    = pc_clear_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scripted cycle-by-cycle bench: each driven cycle queues the output vector expected
// for that cycle, and a negedge checker pops and compares it against the DUT.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        asyncclear_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, mem_ack = 1'b0, exec_done = 1'b0;
  logic [15:0] ir_q = 16'h0000;
  logic        mem_rd, ar_load, pc_inc, pc_clear, ir_load, instr_valid, busy, timeout_err;
  logic [1:0]  ar_src;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;
  exp_t sb_q[$];

  fetch_sequencer #(.DW(16), .AW(12), .TIMEOUT(15)) dut (
    .clk(clk), .asyncclear_n(asyncclear_n), .start(start), .halt(halt),
    .mem_ack(mem_ack), .ir_q(ir_q), .exec_done(exec_done), .mem_rd(mem_rd),
    .ar_load(ar_load), .ar_src(ar_src), .pc_inc(pc_inc), .pc_clear(pc_clear),
    .ir_load(ir_load), .instr_valid(instr_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // {mem_rd, ar_load, ar_src, pc_inc, pc_clear, ir_load, instr_valid, busy, timeout_err}
  function automatic logic [9:0] ov(logic rd, logic ld, logic [1:0] src, logic inc,
                                    logic clr, logic irl, logic iv, logic bsy, logic te);
    return {rd, ld, src, inc, clr, irl, iv, bsy, te};
  endfunction

  localparam logic [9:0] V_IDLE = 10'h000;
  logic [9:0] v_boot, v_t0, v_rdw, v_t1a, v_t2, v_t3a, v_ex, v_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_val(e.tag,
                {22'd0, mem_rd, ar_load, ar_src, pc_inc, pc_clear, ir_load, instr_valid, busy, timeout_err},
                {22'd0, e.exp});
    end
  end

  // One clock cycle: drive inputs just after the edge, queue the outputs expected this cycle.
  task automatic cyc(input string tag, input logic rst_n, input logic st, input logic hl,
                     input logic ack, input logic ed, input logic [15:0] ir, input logic [9:0] exp);
    @(posedge clk);
    #1;
    start = st; halt = hl; mem_ack = ack; exec_done = ed; ir_q = ir;
    asyncclear_n = rst_n;
    sb_q.push_back('{tag: tag, exp: exp});
  endtask

  initial begin
    v_boot = ov(0, 0, 2'd0, 0, 1, 0, 0, 1, 0);
    v_t0   = ov(0, 1, 2'd0, 0, 0, 0, 0, 1, 0);
    v_rdw  = ov(1, 0, 2'd0, 0, 0, 0, 0, 1, 0);
    v_t1a  = ov(1, 0, 2'd0, 1, 0, 1, 0, 1, 0);
    v_t2   = ov(0, 1, 2'd1, 0, 0, 0, 0, 1, 0);
    v_t3a  = ov(1, 1, 2'd2, 0, 0, 0, 0, 1, 0);
    v_ex   = ov(0, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    v_err  = ov(0, 0, 2'd0, 0, 0, 0, 0, 0, 1);

    cyc("rst_a", 0, 0, 0, 0, 0, 16'h0000, V_IDLE);
    cyc("rst_b", 0, 1, 0, 1, 0, 16'h0000, V_IDLE);

    // Direct fetch with zero-wait memory
    cyc("t1_idle", 1, 1, 0, 1, 0, 16'h0123, V_IDLE);
    cyc("t1_boot", 1, 1, 0, 1, 0, 16'h0123, v_boot);
    cyc("t1_t0",   1, 0, 0, 1, 0, 16'h0123, v_t0);
    cyc("t1_t1",   1, 0, 0, 1, 0, 16'h0123, v_t1a);
    cyc("t1_t2",   1, 0, 0, 1, 0, 16'h0123, v_t2);
    cyc("t1_ex",   1, 0, 0, 0, 0, 16'h0123, v_ex);
    cyc("t1_exd",  1, 1, 0, 0, 1, 16'h0123, v_ex);

    // Indirect fetch, two wait cycles in T3, then halt seen in EX
    cyc("t2_t0",   1, 0, 0, 0, 0, 16'h8045, v_t0);
    cyc("t2_t1",   1, 0, 0, 1, 0, 16'h8045, v_t1a);
    cyc("t2_t2",   1, 0, 0, 0, 0, 16'h8045, v_t2);
    cyc("t2_t3w1", 1, 0, 0, 0, 0, 16'h8045, v_rdw);
    cyc("t2_t3w2", 1, 0, 0, 0, 0, 16'h8045, v_rdw);
    cyc("t2_t3a",  1, 0, 0, 1, 0, 16'h8045, v_t3a);
    cyc("t2_exh",  1, 0, 1, 0, 1, 16'h8045, v_ex);
    cyc("t2_idle", 1, 0, 0, 0, 0, 16'h8045, V_IDLE);
    cyc("t2_rest", 1, 1, 0, 0, 0, 16'h8045, V_IDLE);
    cyc("t2_nobt", 1, 0, 0, 0, 0, 16'h0123, v_t0);

    // Halt pulsed during T1 completes the instruction first
    cyc("t4_t1h",  1, 0, 1, 0, 0, 16'h0123, v_rdw);
    cyc("t4_t1a",  1, 0, 0, 1, 0, 16'h0123, v_t1a);
    cyc("t4_t2",   1, 0, 0, 0, 0, 16'h0123, v_t2);
    cyc("t4_ex",   1, 0, 0, 0, 0, 16'h0123, v_ex);
    cyc("t4_exd",  1, 0, 0, 0, 1, 16'h0123, v_ex);
    cyc("t4_idle", 1, 1, 0, 0, 0, 16'h0123, V_IDLE);
    cyc("t4_nobt", 1, 0, 0, 0, 0, 16'h0123, v_t0);

    // No ack for the full timeout window
    for (int i = 0; i < 15; i++) cyc("t3_wait", 1, 0, 0, 0, 0, 16'h0123, v_rdw);
    cyc("t3_err",  1, 0, 0, 0, 0, 16'h0123, v_err);
    cyc("t3_errs", 1, 1, 0, 0, 0, 16'h0123, v_err);
    cyc("t3_boot", 1, 0, 0, 0, 0, 16'h0123, v_boot);
    cyc("t3_t0",   1, 0, 0, 0, 0, 16'h0123, v_t0);

    // Ack on the last allowed cycle wins over the timeout
    for (int i = 0; i < 14; i++) cyc("t6_wait", 1, 0, 0, 0, 0, 16'h0123, v_rdw);
    cyc("t6_ack",  1, 0, 0, 1, 0, 16'h0123, v_t1a);
    cyc("t6_t2",   1, 0, 0, 0, 0, 16'h0123, v_t2);
    cyc("t6_ex",   1, 0, 0, 0, 1, 16'h0123, v_ex);

    // Async reset in T3 with ack asserted
    cyc("t5_t0",   1, 0, 0, 0, 0, 16'h8045, v_t0);
    cyc("t5_t1",   1, 0, 0, 1, 0, 16'h8045, v_t1a);
    cyc("t5_t2",   1, 0, 0, 0, 0, 16'h8045, v_t2);
    cyc("t5_t3w",  1, 0, 0, 0, 0, 16'h8045, v_rdw);
    cyc("t5_rst",  0, 0, 0, 1, 0, 16'h8045, V_IDLE);
    cyc("t5_rel",  1, 0, 0, 1, 0, 16'h8045, V_IDLE);
    cyc("t5_st",   1, 1, 0, 0, 0, 16'h0123, V_IDLE);
    cyc("t5_boot", 1, 0, 0, 0, 0, 16'h0123, v_boot);
    cyc("t5_t0",   1, 0, 0, 0, 0, 16'h0123, v_t0);

    @(posedge clk);
    @(posedge clk);
    check_val("drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
